mux_key_with_default_reg: RTL and testbench
===========================================

Name: mux_key_with_default_reg

Overview:
- Registered key-lookup multiplexer: compares an input key against NR_KEY programmable {key, data} pairs.
- Outputs the data of the matching entry, or a supplied default when no entry matches.
- Used as the generic decode/selection primitive in the control unit, e.g. ALU function select, ALU inside-control select and immediate-type select.
- Differs from the purely combinational lookup: the result is captured in an output register.

Parameters:
- NR_KEY, 2, number of {key, data} pairs in the lookup table (≥1).
- KEY_LEN, 1, width of each key and of the key input (≥1).
- DATA_LEN, 1, width of each data entry, default_out and out (≥1).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key  input  KEY_LEN  value to look up.
- default_out  input  DATA_LEN  value selected when no table key equals key.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed table. Layout:
  - Pair i occupies bits [(i+1)*P-1 : i*P], where P = KEY_LEN+DATA_LEN.
  - Within a pair, the key is in the upper KEY_LEN bits and the data in the lower DATA_LEN bits.
  - The first pair written in a concatenation list is the highest index (NR_KEY-1).
- out  output  DATA_LEN  registered lookup result.
- hit  output  1  registered flag: 1 when at least one table key matched.

Behaviour:
- Reset: asserting rst_n=0 immediately (asynchronously) forces out=0 and hit=0. Both hold while rst_n=0.
- Release: on deassertion, the first rising clk edge with rst_n=1 loads normal results.
- Combinational lookup each cycle:
  - match[i] = (lut key field i == key), with exact equality over all KEY_LEN bits.
  - sel_data = bitwise OR over i of (match[i] ? data_i : 0).
  - any = OR of match[i].
  - next_out = any ? sel_data : default_out.
- Registered output: at each rising clk edge, out <= next_out and hit <= any. Latency is exactly 1 cycle from key/lut/default_out change to out.
- Multiple matches: duplicate keys are legal. The result is the bitwise OR of all matching data entries; no priority between entries. Example: two entries keyed 0x002 with data 7 and 8 give out=15.
- No match: out=default_out, hit=0. default_out is sampled at the same edge as key.
- Table and default are treated as ordinary data inputs. They may change every cycle and take effect at the next edge, like key.
- No X propagation requirement beyond standard synthesis semantics; no internal state other than the out/hit registers.
- Mid-operation reset clears out/hit with no clock required. The lookup in progress is discarded, not completed.

Test Plan:
- Reset: NR_KEY=6, KEY_LEN=6, DATA_LEN=4, key=6'b100000 with entry {6'b100000,0} present, rst_n=0 -> out=0, hit=0 before any clock edge. Release, one edge -> out=0, hit=1.
- Single hits, same config with entries {100000→0, 010000→1, 001000→2, 000100→3, 000010→4, 000001→5} and default_out=15:
  - key=6'b001000 -> after one edge out=2, hit=1.
  - key=6'b000001 -> after one edge out=5, hit=1.
- Miss: key=6'b110000 (two bits set), default_out=15 -> out=15, hit=0. Change default_out to 9 -> next edge out=9.
- Duplicate keys: NR_KEY=12, KEY_LEN=12, entries 0x002→7 and 0x002→8 -> key=0x002 gives out=15, hit=1. key=0x004 mapped to 6 gives out=6.
- Latency: toggle key between 6'b100000 and 6'b000010 every cycle -> out follows one cycle later (0,4,0,4…). It never changes between edges.
- Async reset mid-stream: with out=4, pull rst_n low between edges -> out=0 immediately. Release -> next edge shows current lookup.

Source files
------------

// File: rtl/mux_key_with_default_reg_if.sv
// rtl/mux_key_with_default_reg_if.sv - lookup bus bundle for the registered key mux
//
// Purpose: groups the lookup inputs (key, default, packed table) and the
// registered results (out, hit) so they can be passed as a single port.
// Ports (signals):
//   key          KEY_LEN                        value to look up
//   default_out  DATA_LEN                       result when no table key matches
//   lut          NR_KEY*(KEY_LEN+DATA_LEN)      packed {key,data} pairs, pair i at [(i+1)*P-1 : i*P]
//   out          DATA_LEN                       registered lookup result
//   hit          1                              registered "some key matched" flag
// Modports: master drives the lookup inputs, slave is the lookup block.
interface mux_key_with_default_reg_if #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
);
  logic [KEY_LEN-1:0]                   key;
  logic [DATA_LEN-1:0]                  default_out;
  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut;
  logic [DATA_LEN-1:0]                  out;
  logic                                 hit;

  modport master (
    output key, default_out, lut,
    input  out, hit
  );

  modport slave (
    input  key, default_out, lut,
    output out, hit
  );
endinterface

// File: rtl/mux_key_with_default_reg.sv
// rtl/mux_key_with_default_reg.sv - registered key lookup mux with default value
//
// Purpose: compares key against NR_KEY {key,data} pairs from the packed table
// and registers the OR of all matching data entries, or default_out when
// nothing matches. Used as the generic decode primitive in the control unit.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears out and hit
//   bus    lookup bundle (slave side): key, default_out, lut in; out, hit out
module mux_key_with_default_reg #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mux_key_with_default_reg_if.slave   bus
);
  localparam int P = KEY_LEN + DATA_LEN;

  logic [DATA_LEN-1:0] sel_data;
  logic                any;
  logic [DATA_LEN-1:0] next_out;
  logic [DATA_LEN-1:0] out_q;
  logic                hit_q;

  // Duplicate keys are legal: every matching entry contributes its data via
  // OR, so there is deliberately no priority between table positions.
  always_comb begin
    sel_data = '0;
    any      = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (bus.lut[i*P+DATA_LEN +: KEY_LEN] == bus.key) begin
        sel_data = sel_data | bus.lut[i*P +: DATA_LEN];
        any      = 1'b1;
      end
    end
    next_out = any ? sel_data : bus.default_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= next_out;
      hit_q <= any;
    end
  end

  assign bus.out = out_q;
  assign bus.hit = hit_q;
endmodule

// File: tb/tb_mux_key_with_default_reg.sv
// tb/tb_mux_key_with_default_reg.sv - self-checking bench for mux_key_with_default_reg
module tb_mux_key_with_default_reg;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux_key_with_default_reg_if #(.NR_KEY(6),  .KEY_LEN(6),  .DATA_LEN(4)) if6 ();
  mux_key_with_default_reg_if #(.NR_KEY(12), .KEY_LEN(12), .DATA_LEN(4)) if12 ();

  mux_key_with_default_reg #(.NR_KEY(6), .KEY_LEN(6), .DATA_LEN(4)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if6)
  );

  mux_key_with_default_reg #(.NR_KEY(12), .KEY_LEN(12), .DATA_LEN(4)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if12)
  );

  // Table contents held as plain arrays; the packed lut is derived from them.
  logic [5:0]  k6  [6];
  logic [3:0]  d6  [6];
  logic [11:0] k12 [12];
  logic [3:0]  d12 [12];

  always_comb begin
    if6.lut = '0;
    for (int i = 0; i < 6; i++) if6.lut[i*10 +: 10] = {k6[i], d6[i]};
  end

  always_comb begin
    if12.lut = '0;
    for (int i = 0; i < 12; i++) if12.lut[i*16 +: 16] = {k12[i], d12[i]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: gather data of all matching entries in a queue, OR them,
  // fall back to the default when the queue is empty.
  function automatic void ref6(input logic [5:0] k, input logic [3:0] def,
                               output logic [3:0] eo, output logic eh);
    logic [3:0] hits [$];
    logic [3:0] acc;
    for (int i = 0; i < 6; i++) if (k6[i] == k) hits.push_back(d6[i]);
    acc = 4'd0;
    foreach (hits[j]) acc = acc | hits[j];
    eh = (hits.size() != 0);
    eo = eh ? acc : def;
  endfunction

  function automatic void ref12(input logic [11:0] k, input logic [3:0] def,
                                output logic [3:0] eo, output logic eh);
    logic [3:0] hits [$];
    logic [3:0] acc;
    for (int i = 0; i < 12; i++) if (k12[i] == k) hits.push_back(d12[i]);
    acc = 4'd0;
    foreach (hits[j]) acc = acc | hits[j];
    eh = (hits.size() != 0);
    eo = eh ? acc : def;
  endfunction

  task automatic load_onehot_table();
    for (int i = 0; i < 6; i++) begin
      k6[i] = 6'b100000 >> i;
      d6[i] = 4'(i);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    load_onehot_table();
    for (int i = 0; i < 12; i++) begin
      k12[i] = 12'h800 + 12'(i);
      d12[i] = 4'(i);
    end
    if6.key = 6'b100000;
    if6.default_out = 4'd15;
    if12.key = 12'h000;
    if12.default_out = 4'd3;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (if6.out !== 4'd0 || if6.hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: out=%0d hit=%0b required out=0 hit=0", if6.out, if6.hit);
    end
    step();
    step();
    checks++;
    if (if6.out !== 4'd0 || if6.hit !== 1'b0 || if12.out !== 4'd0 || if12.hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: out6=%0d hit6=%0b out12=%0d hit12=%0b required all 0",
               if6.out, if6.hit, if12.out, if12.hit);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (if6.out !== 4'd0 || if6.hit !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: out=%0d hit=%0b required out=0 hit=1", if6.out, if6.hit);
    end
    checks++;
    if (if12.out !== 4'd3 || if12.hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_release12: out=%0d hit=%0b required out=3 hit=0", if12.out, if12.hit);
    end
  endtask

  task automatic test_single_hits();
    logic [5:0] keys [2];
    logic [3:0] want [2];
    keys[0] = 6'b001000; want[0] = 4'd2;
    keys[1] = 6'b000001; want[1] = 4'd5;
    load_onehot_table();
    if6.default_out = 4'd15;
    for (int i = 0; i < 2; i++) begin
      if6.key = keys[i];
      step();
      checks++;
      if (if6.out !== want[i] || if6.hit !== 1'b1) begin
        failures++;
        $display("FAIL single_hit key=%b: out=%0d hit=%0b required out=%0d hit=1",
                 keys[i], if6.out, if6.hit, want[i]);
      end
    end
  endtask

  task automatic test_miss();
    if6.key = 6'b110000;
    if6.default_out = 4'd15;
    step();
    checks++;
    if (if6.out !== 4'd15 || if6.hit !== 1'b0) begin
      failures++;
      $display("FAIL miss_default15: out=%0d hit=%0b required out=15 hit=0", if6.out, if6.hit);
    end
    if6.default_out = 4'd9;
    step();
    checks++;
    if (if6.out !== 4'd9 || if6.hit !== 1'b0) begin
      failures++;
      $display("FAIL miss_default9: out=%0d hit=%0b required out=9 hit=0", if6.out, if6.hit);
    end
  endtask

  task automatic test_duplicate_keys();
    for (int i = 0; i < 12; i++) begin
      k12[i] = 12'h100 + 12'(i);
      d12[i] = 4'(i);
    end
    k12[0] = 12'h002; d12[0] = 4'd7;
    k12[5] = 12'h002; d12[5] = 4'd8;
    k12[9] = 12'h004; d12[9] = 4'd6;
    if12.default_out = 4'd0;
    if12.key = 12'h002;
    step();
    checks++;
    if (if12.out !== 4'd15 || if12.hit !== 1'b1) begin
      failures++;
      $display("FAIL dup_or: out=%0d hit=%0b required out=15 hit=1", if12.out, if12.hit);
    end
    if12.key = 12'h004;
    step();
    checks++;
    if (if12.out !== 4'd6 || if12.hit !== 1'b1) begin
      failures++;
      $display("FAIL dup_single: out=%0d hit=%0b required out=6 hit=1", if12.out, if12.hit);
    end
  endtask

  task automatic test_latency();
    logic [3:0] eo;
    logic       eh;
    load_onehot_table();
    if6.default_out = 4'd15;
    for (int i = 0; i < 8; i++) begin
      if6.key = (i % 2 == 0) ? 6'b100000 : 6'b000010;
      ref6(if6.key, if6.default_out, eo, eh);
      step();
      checks++;
      if (if6.out !== eo || if6.hit !== eh) begin
        failures++;
        $display("FAIL latency_edge i=%0d: out=%0d hit=%0b required out=%0d hit=%0b",
                 i, if6.out, if6.hit, eo, eh);
      end
      @(negedge clk);
      checks++;
      if (if6.out !== eo) begin
        failures++;
        $display("FAIL latency_between i=%0d: out=%0d required out=%0d", i, if6.out, eo);
      end
    end
  endtask

  task automatic test_async_reset_mid();
    load_onehot_table();
    if6.key = 6'b000010;
    step();
    checks++;
    if (if6.out !== 4'd4) begin
      failures++;
      $display("FAIL midreset_pre: out=%0d required out=4", if6.out);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (if6.out !== 4'd0 || if6.hit !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear: out=%0d hit=%0b required out=0 hit=0", if6.out, if6.hit);
    end
    #1 rst_n = 1'b1;
    if6.key = 6'b010000;
    step();
    checks++;
    if (if6.out !== 4'd1 || if6.hit !== 1'b1) begin
      failures++;
      $display("FAIL midreset_resume: out=%0d hit=%0b required out=1 hit=1", if6.out, if6.hit);
    end
  endtask

  // Small key alphabets so that hits, misses and duplicates all occur often;
  // table, key and default all change every cycle.
  task automatic test_random();
    logic [3:0] eo6, eo12;
    logic       eh6, eh12;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 6; i++) begin
        k6[i] = 6'($urandom_range(0, 9));
        d6[i] = 4'($urandom);
      end
      for (int i = 0; i < 12; i++) begin
        k12[i] = 12'($urandom_range(0, 15)) | ((n % 3 == 0) ? 12'hA00 : 12'h000);
        d12[i] = 4'($urandom);
      end
      if6.key = 6'($urandom_range(0, 9));
      if6.default_out = 4'($urandom);
      if12.key = 12'($urandom_range(0, 15));
      if12.default_out = 4'($urandom);
      ref6(if6.key, if6.default_out, eo6, eh6);
      ref12(if12.key, if12.default_out, eo12, eh12);
      step();
      checks++;
      if (if6.out !== eo6 || if6.hit !== eh6) begin
        failures++;
        $display("FAIL random6 n=%0d: out=%0d hit=%0b required out=%0d hit=%0b",
                 n, if6.out, if6.hit, eo6, eh6);
      end
      checks++;
      if (if12.out !== eo12 || if12.hit !== eh12) begin
        failures++;
        $display("FAIL random12 n=%0d: out=%0d hit=%0b required out=%0d hit=%0b",
                 n, if12.out, if12.hit, eo12, eh12);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_hits();
    test_miss();
    test_duplicate_keys();
    test_latency();
    test_async_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
